display_scheduler: RTL

//  Sequences the 7-seg display path. Owns display-state timing: score view by default, and high-score view
//   for a fixed hold time after a request.

---
 rtl/display_scheduler_pkg.sv | 39 +++
 rtl/display_scheduler_if.sv | 27 ++
 rtl/display_scheduler_bin2dec_serial.sv | 95 +++++++++
 rtl/display_scheduler.sv | 65 ++++++
 4 files changed

// File: rtl/display_scheduler_pkg.sv
// Shared encodings for the display path: display-state and conversion-engine states,
// decimal power table, character codes and the leading-zero mask helper.
package display_pkg;

    typedef enum logic {
        GAME_ON   = 1'b0,
        HIGHSCORE = 1'b1
    } disp_state_t;

    typedef enum logic [1:0] {
        CS_IDLE = 2'd0,
        CS_CONV = 2'd1,
        CS_DONE = 2'd2
    } conv_state_t;

    localparam int HOLD_CNT_W = 12;

    // Indexed by digit position: DEC_POWER[4] is the ten-thousands weight.
    localparam logic [16:0] DEC_POWER [4:0] = '{17'd10000, 17'd1000, 17'd100, 17'd10, 17'd1};

    localparam logic [4:0] CHAR_R     = 5'd16;
    localparam logic [4:0] CHAR_O     = 5'd17;
    localparam logic [4:0] CHAR_G     = 5'd18;
    localparam logic [4:0] CHAR_BLANK = 5'd31;

    // Bit i set when digits 4..i are all zero; digit 0 always stays visible.
    function automatic logic [4:0] lz_mask(input logic [4:0][3:0] d);
        logic [4:0] m;
        logic       all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int i = 4; i >= 1; i--) begin
            all_zero = all_zero && (d[i] == 4'd0);
            m[i]     = all_zero;
        end
        return m;
    endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Bundle between game logic / display driver and the scheduler, plus debug state taps.
// showHighReq and oneMsPulse are single-cycle pulses sampled on every rising clock edge.
interface display_scheduler_if;
    import display_pkg::*;

    logic                  oneMsPulse;
    logic                  showHighReq;
    logic [15:0]           score;
    disp_state_t           displayState;
    logic [19:0]           decDigits;
    logic                  decValid;
    logic                  convBusy;
    logic [4:0]            blankMask;
    logic [HOLD_CNT_W-1:0] holdCnt;
    conv_state_t           convState;

    modport master (
        output oneMsPulse, showHighReq, score,
        input  displayState, decDigits, decValid, convBusy, blankMask, holdCnt, convState
    );

    modport slave (
        input  oneMsPulse, showHighReq, score,
        output displayState, decDigits, decValid, convBusy, blankMask, holdCnt, convState
    );

endinterface

// File: rtl/display_scheduler_bin2dec_serial.sv
// Serial binary-to-BCD converter: one subtract-by-power-of-ten or digit step per cycle.
// Optional leading-zero blank mask is built when DISP_LZ_BLANK_EN is defined.
module bin2dec_serial
    import display_pkg::*;
#(
    parameter int SCORE_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [SCORE_W-1:0] i_score,
    output logic [19:0]        o_digits,
    output logic               o_valid,
    output logic               o_busy,
    output logic [4:0]         o_blank,
    output conv_state_t        o_state
);

    conv_state_t        r_state;
    logic [SCORE_W-1:0] r_capt;
    logic [16:0]        r_tmp;
    logic [4:0][3:0]    r_work;
    logic [2:0]         r_p;
    logic [19:0]        r_digits;
    logic               r_valid;
    logic               r_busy;
    logic [16:0]        w_pow;

    assign w_pow = DEC_POWER[r_p];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= CS_IDLE;
            r_capt   <= '0;
            r_tmp    <= '0;
            r_work   <= '0;
            r_p      <= '0;
            r_digits <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                CS_IDLE: begin
                    // A score change during CONV is caught here once the old conversion lands.
                    if (i_score != r_capt) begin
                        r_capt  <= i_score;
                        r_tmp   <= 17'(i_score);
                        r_work  <= '0;
                        r_p     <= 3'd4;
                        r_busy  <= 1'b1;
                        r_state <= CS_CONV;
                    end
                end
                CS_CONV: begin
                    if (r_tmp >= w_pow) begin
                        r_tmp       <= r_tmp - w_pow;
                        r_work[r_p] <= r_work[r_p] + 4'd1;
                    end else if (r_p == 3'd0) begin
                        r_state <= CS_DONE;
                    end else begin
                        r_p <= r_p - 3'd1;
                    end
                end
                CS_DONE: begin
                    r_digits <= r_work;
                    r_valid  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= CS_IDLE;
                end
                default: r_state <= CS_IDLE;
            endcase
        end
    end

`ifdef DISP_LZ_BLANK_EN
    logic [4:0] r_blank;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blank <= '0;
        end else if (r_state == CS_DONE) begin
            r_blank <= lz_mask(r_work);
        end
    end

    assign o_blank = r_blank;
`else
    assign o_blank = '0;
`endif

    assign o_digits = r_digits;
    assign o_valid  = r_valid;
    assign o_busy   = r_busy;
    assign o_state  = r_state;

endmodule

// File: rtl/display_scheduler.sv
// Display sequencer: GAME_ON / HIGHSCORE view with ms hold timer, plus serial BCD conversion.
// Build option DISP_LZ_BLANK_EN enables the leading-zero blank mask.
module display_scheduler
    import display_pkg::*;
#(
    parameter int HOLD_MS = 3000,
    parameter int SCORE_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    display_scheduler_if.slave  bus
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_MS - 1);

    disp_state_t           r_disp;
    logic [HOLD_CNT_W-1:0] r_hold;

    // A request in HIGHSCORE restarts the hold and takes priority over a same-cycle tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_disp <= GAME_ON;
            r_hold <= '0;
        end else begin
            case (r_disp)
                GAME_ON: begin
                    if (bus.showHighReq) begin
                        r_disp <= HIGHSCORE;
                        r_hold <= '0;
                    end
                end
                HIGHSCORE: begin
                    if (bus.showHighReq) begin
                        r_hold <= '0;
                    end else if (bus.oneMsPulse) begin
                        if (r_hold == HOLD_LAST) begin
                            r_disp <= GAME_ON;
                            r_hold <= '0;
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                end
                default: r_disp <= GAME_ON;
            endcase
        end
    end

    assign bus.displayState = r_disp;
    assign bus.holdCnt      = r_hold;

    bin2dec_serial #(
        .SCORE_W (SCORE_W)
    ) u_bin2dec (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_score  (bus.score),
        .o_digits (bus.decDigits),
        .o_valid  (bus.decValid),
        .o_busy   (bus.convBusy),
        .o_blank  (bus.blankMask),
        .o_state  (bus.convState)
    );

endmodule
